// File: rtl/spatz_simd_red_seq_pkg.sv
// Types shared by the reduction sequencer and its lane-facing ports.
//   op_e  : reduction operation forwarded to the lane
//   vew_e : element width selector
package spatz_simd_red_seq_pkg;

    typedef enum logic [3:0] {
        VADD  = 4'd0,
        VMIN  = 4'd1,
        VMINU = 4'd2,
        VMAX  = 4'd3,
        VMAXU = 4'd4,
        VAND  = 4'd5,
        VOR   = 4'd6,
        VXOR  = 4'd7
    } op_e;

    typedef enum logic [1:0] {
        EW_8  = 2'd0,
        EW_16 = 2'd1,
        EW_32 = 2'd2,
        EW_64 = 2'd3
    } vew_e;

endpackage

// File: rtl/spatz_simd_red_seq_if.sv
// Valid/ready stream carrying one Width-bit word per beat.
//   valid : producer has a word on data
//   ready : consumer accepts the word this cycle
//   data  : payload
// master = producer side, slave = consumer side.
interface spatz_simd_red_seq_if #(
    parameter int unsigned Width = 32
);
    logic             valid;
    logic             ready;
    logic [Width-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/spatz_simd_red_seq.sv
// Reduction sequencer wrapped around one combinational SIMD lane. It feeds the
// lane the running accumulator and one streamed element per cycle, captures the
// lane result back into the accumulator and, after vl elements, presents a single
// scalar result.
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i/start_ready_o start a reduction (accepted in IDLE only)
//   op_i, is_signed_i, sew_i, vl_i, init_i  reduction configuration and seed
//   clear_i              synchronous abort back to IDLE
//   elem (slave)         element stream from the register file
//   lane_*               drive/return of the external lane
//   result (master)      scalar result, held until accepted
//   busy_o               sequencer not idle
//
// state | meaning
// IDLE  | waiting for start, start_ready_o high
// ACCUM | consuming elements, acc <= lane result on each handshake
// DONE  | result_valid high until the consumer takes it
module spatz_simd_red_seq
    import spatz_simd_red_seq_pkg::*;
#(
    parameter int unsigned Width    = 32,
    parameter int unsigned CntWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    output logic                 start_ready_o,
    input  op_e                  op_i,
    input  logic                 is_signed_i,
    input  vew_e                 sew_i,
    input  logic [CntWidth-1:0]  vl_i,
    input  logic [Width-1:0]     init_i,
    input  logic                 clear_i,
    spatz_simd_red_seq_if.slave  elem,
    output op_e                  lane_op_o,
    output logic [Width-1:0]     lane_s1_o,
    output logic [Width-1:0]     lane_s2_o,
    output logic [Width-1:0]     lane_d_o,
    output logic                 lane_is_signed_o,
    output logic                 lane_carry_o,
    output vew_e                 lane_sew_o,
    input  logic [Width-1:0]     lane_result_i,
    spatz_simd_red_seq_if.master result,
    output logic                 busy_o
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

    state_e              state_q, state_d;
    logic [Width-1:0]    acc_q, acc_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    op_e                 op_q;
    vew_e                sew_q;
    logic                sgn_q;
    logic                latch_cfg;
    logic                elem_hs;

    // Keep the low SEW bits; fill the rest with the SEW sign bit when sgn is set,
    // otherwise with zeros. Lets the lane compare full-width values at any SEW.
    function automatic logic [Width-1:0] ext_f(input logic [Width-1:0] x,
                                               input logic sgn, input vew_e sew);
        logic [Width-1:0] res;
        logic             sbit;
        int               nbits;
        case (sew)
            EW_8:    nbits = 8;
            EW_16:   nbits = 16;
            default: nbits = 32;
        endcase
        if (nbits > int'(Width)) nbits = int'(Width);
        sbit = 1'b0;
        for (int i = 0; i < int'(Width); i++) begin
            if (i == nbits - 1) sbit = x[i] & sgn;
        end
        for (int i = 0; i < int'(Width); i++) begin
            res[i] = (i < nbits) ? x[i] : sbit;
        end
        return res;
    endfunction

    assign elem_hs = elem.valid && (state_q == ACCUM);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        latch_cfg = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        latch_cfg = 1'b1;
                        acc_d     = ext_f(init_i, is_signed_i, sew_i);
                        cnt_d     = vl_i;
                        state_d   = (vl_i == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (elem_hs) begin
                        acc_d = lane_result_i;
                        cnt_d = cnt_q - CntWidth'(1);
                        if (cnt_q == CntWidth'(1)) state_d = DONE;
                    end
                end
                DONE: begin
                    if (result.ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            cnt_q <= '0;
            op_q  <= VADD;
            sew_q <= EW_8;
            sgn_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (latch_cfg) begin
                op_q  <= op_i;
                sew_q <= sew_i;
                sgn_q <= is_signed_i;
            end
        end
    end

    assign start_ready_o    = (state_q == IDLE);
    assign busy_o           = (state_q != IDLE);
    assign elem.ready       = (state_q == ACCUM);
    assign result.valid     = (state_q == DONE);
    assign result.data      = ext_f(acc_q, 1'b0, sew_q);

    assign lane_op_o        = op_q;
    assign lane_sew_o       = sew_q;
    assign lane_is_signed_o = sgn_q;
    assign lane_s1_o        = acc_q;
    assign lane_s2_o        = ext_f(elem.data, sgn_q, sew_q);
    assign lane_d_o         = '0;
    assign lane_carry_o     = 1'b0;

    a_legal_op: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (start_i && start_ready_o) |-> (op_i inside {VADD, VMIN, VMINU, VMAX,
                                                     VMAXU, VAND, VOR, VXOR}));

endmodule
